// File: rtl/pulse_sched_if.sv
// Peripheral-bus port bundle for pulse_sched. The master drives write strobe,
// address and write data. The slave returns combinational read data.
interface pulse_sched_if;
  logic        we_i;
  logic [7:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, output addr_i, output data_i, input data_o);
  modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/pulse_sched.sv
// Multi-channel pulse/PWM scheduler with double-buffered period/duty, finite
// bursts and a level interrupt on burst completion.
module pulse_sched #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  pulse_sched_if.slave      bus,
  output logic [NUM_CH-1:0] pulse_o,
  output logic              irq_o
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  typedef struct packed {
    state_t      state;
    logic        irq_en;
    logic        done;
    logic [31:0] period_sh;
    logic [31:0] duty_sh;
    logic [31:0] burst;
    logic [31:0] period_act;
    logic [31:0] duty_act;
    logic [31:0] cntr;
    logic [31:0] per_cnt;
  } ch_t;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_PERIOD = 2'd1;
  localparam logic [1:0] R_DUTY   = 2'd2;
  localparam logic [1:0] R_BURST  = 2'd3;

  ch_t ch_q [NUM_CH];

  logic [2:0] ch_idx;
  logic [1:0] reg_idx;
  logic [2:0] unused_addr;

  assign ch_idx      = bus.addr_i[6:4];
  assign reg_idx     = bus.addr_i[3:2];
  assign unused_addr = {bus.addr_i[7], bus.addr_i[1:0]};

  logic [NUM_CH-1:0] ctrl_wr, period_wr, duty_wr, burst_wr;
  logic [NUM_CH-1:0] start_req, stop_req, clr_done, boundary, burst_end, set_done;

  // Channels outside NUM_CH never match the decode, so their writes vanish.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ctrl_wr   = '0;
    period_wr = '0;
    duty_wr   = '0;
    burst_wr  = '0;
    start_req = '0;
    stop_req  = '0;
    clr_done  = '0;
    boundary  = '0;
    burst_end = '0;
    set_done  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ctrl_wr[i]   = bus.we_i && (ch_idx == 3'(i)) && (reg_idx == R_CTRL);
      period_wr[i] = bus.we_i && (ch_idx == 3'(i)) && (reg_idx == R_PERIOD);
      duty_wr[i]   = bus.we_i && (ch_idx == 3'(i)) && (reg_idx == R_DUTY);
      burst_wr[i]  = bus.we_i && (ch_idx == 3'(i)) && (reg_idx == R_BURST);
      stop_req[i]  = ctrl_wr[i] && bus.data_i[1];
      start_req[i] = ctrl_wr[i] && bus.data_i[0] && !bus.data_i[1] &&
                     (ch_q[i].period_sh != 32'd0);
      clr_done[i]  = ctrl_wr[i] && bus.data_i[8];
      boundary[i]  = (ch_q[i].state == S_RUN) &&
                     (ch_q[i].cntr == ch_q[i].period_act - 32'd1);
      // Using >= lets a BURST lowered mid-run terminate at the next boundary.
      burst_end[i] = boundary[i] && (ch_q[i].burst != 32'd0) &&
                     (ch_q[i].per_cnt >= ch_q[i].burst - 32'd1);
      set_done[i]  = burst_end[i] && !start_req[i] && !stop_req[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the per-channel register array is reset because software reads it back as zeros after reset.
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ctrl_wr[i])   ch_q[i].irq_en    <= bus.data_i[2];
        if (period_wr[i]) ch_q[i].period_sh <= bus.data_i;
        if (duty_wr[i])   ch_q[i].duty_sh   <= bus.data_i;
        if (burst_wr[i])  ch_q[i].burst     <= bus.data_i;

        // Completion outranks a same-edge write-1-to-clear.
        if (set_done[i])      ch_q[i].done <= 1'b1;
        else if (clr_done[i]) ch_q[i].done <= 1'b0;

        if (stop_req[i]) begin
          ch_q[i].state <= S_IDLE;
          ch_q[i].cntr  <= '0;
        end else if (start_req[i]) begin
          ch_q[i].state      <= S_RUN;
          ch_q[i].period_act <= ch_q[i].period_sh;
          ch_q[i].duty_act   <= ch_q[i].duty_sh;
          ch_q[i].cntr       <= '0;
          ch_q[i].per_cnt    <= '0;
        end else if (ch_q[i].state == S_RUN) begin
          if (boundary[i]) begin
            ch_q[i].cntr       <= '0;
            ch_q[i].per_cnt    <= ch_q[i].per_cnt + 32'd1;
            ch_q[i].period_act <= ch_q[i].period_sh;
            ch_q[i].duty_act   <= ch_q[i].duty_sh;
            if (burst_end[i] || (ch_q[i].period_sh == 32'd0))
              ch_q[i].state <= S_IDLE;
          end else begin
            ch_q[i].cntr <= ch_q[i].cntr + 32'd1;
          end
        end
      end
    end
  end

  // Outputs compare registered state directly, so a start is visible the next cycle.
  always_comb begin
    pulse_o = '0;
    irq_o   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      pulse_o[i] = (ch_q[i].state == S_RUN) && (ch_q[i].cntr < ch_q[i].duty_act);
      irq_o      = irq_o | (ch_q[i].done & ch_q[i].irq_en);
    end
  end

  always_comb begin
    bus.data_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 3'(i)) begin
        case (reg_idx)
          R_CTRL:   bus.data_o = {22'b0, (ch_q[i].state == S_RUN), ch_q[i].done,
                                  5'b0, ch_q[i].irq_en, 2'b0};
          R_PERIOD: bus.data_o = ch_q[i].period_sh;
          R_DUTY:   bus.data_o = ch_q[i].duty_sh;
          R_BURST:  bus.data_o = ch_q[i].burst;
          default:  bus.data_o = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched: bus writes on the falling edge, outputs
// sampled mid-cycle against hand-computed waveforms and register values.
module tb_pulse_sched;

  logic       clk;
  logic       rst;
  logic [3:0] pulse;
  logic       irq;

  int n_vec;
  int n_miss;

  pulse_sched_if bus ();

  pulse_sched #(.NUM_CH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .pulse_o (pulse),
    .irq_o   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; the write lands on the next rising edge and
  // the task returns on the following falling edge.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.data_i = d;
    @(negedge clk);
    bus.we_i   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.addr_i = a;
    #1;
    d = bus.data_o;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [31:0] rdata;
  logic [19:0] w20;
  logic [15:0] w16;
  logic [15:0] i16;
  logic [23:0] w24;
  logic        acc;

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst        = 1'b0;
    bus.we_i   = 1'b0;
    bus.addr_i = '0;
    bus.data_i = '0;

    // Reset state
    #12;
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rd(8'h00, rdata);
    check("rst_ctrl0", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Ch0 continuous 10/3
    wr(8'h04, 32'd10);
    wr(8'h08, 32'd3);
    wr(8'h0C, 32'd0);
    wr(8'h00, 32'h1);
    w20 = '0;
    for (int k = 0; k < 20; k++) begin
      w20 = {w20[18:0], pulse[0]};
      tick();
    end
    check("ch0_wave", 32'(w20), 32'(20'b1110000000_1110000000));
    rd(8'h00, rdata);
    check("ch0_busy", rdata, 32'h200);
    check("ch0_irq", 32'(irq), 32'd0);
    wr(8'h00, 32'h2);
    check("ch0_stopped", 32'(pulse), 32'd0);

    // Ch1 burst of 3, period 4, duty 2, irq enabled
    wr(8'h14, 32'd4);
    wr(8'h18, 32'd2);
    wr(8'h1C, 32'd3);
    wr(8'h10, 32'h5);
    w16 = '0;
    i16 = '0;
    for (int k = 0; k < 16; k++) begin
      w16 = {w16[14:0], pulse[1]};
      i16 = {i16[14:0], irq};
      tick();
    end
    check("ch1_wave", 32'(w16), 32'(16'b1100110011000000));
    check("ch1_irq_wave", 32'(i16), 32'(16'b0000000000001111));
    rd(8'h10, rdata);
    check("ch1_done", rdata, 32'h104);
    wr(8'h10, 32'h104);
    check("ch1_irq_clr", 32'(irq), 32'd0);
    rd(8'h10, rdata);
    check("ch1_ctrl_clr", rdata, 32'h004);

    // Ch0 duty change mid-period takes effect at the next boundary
    wr(8'h04, 32'd8);
    wr(8'h08, 32'd2);
    wr(8'h00, 32'h1);
    w24 = '0;
    for (int k = 0; k < 24; k++) begin
      w24 = {w24[22:0], pulse[0]};
      if (k == 3) wr(8'h08, 32'd6);
      else tick();
    end
    check("dbuf_wave", 32'(w24), 32'(24'b110000001111110011111100));
    wr(8'h00, 32'h2);

    // Duty edge cases and zero period
    wr(8'h08, 32'd0);
    wr(8'h04, 32'd10);
    wr(8'h00, 32'h1);
    acc = 1'b0;
    for (int k = 0; k < 12; k++) begin
      acc = acc | pulse[0];
      tick();
    end
    check("duty0_low", 32'(acc), 32'd0);
    rd(8'h00, rdata);
    check("duty0_busy", rdata, 32'h200);
    wr(8'h00, 32'h2);
    wr(8'h08, 32'd20);
    wr(8'h00, 32'h1);
    acc = 1'b1;
    for (int k = 0; k < 12; k++) begin
      acc = acc & pulse[0];
      tick();
    end
    check("duty20_high", 32'(acc), 32'd1);
    wr(8'h00, 32'h2);
    wr(8'h04, 32'd0);
    wr(8'h00, 32'h1);
    rd(8'h00, rdata);
    check("per0_idle", rdata, 32'd0);
    check("per0_pulse", 32'(pulse), 32'd0);

    // Stop mid-high, then combined start+stop
    wr(8'h04, 32'd10);
    wr(8'h08, 32'd5);
    wr(8'h00, 32'h1);
    tick();
    check("stop_pre", 32'(pulse[0]), 32'd1);
    wr(8'h00, 32'h2);
    check("stop_pulse", 32'(pulse), 32'd0);
    rd(8'h00, rdata);
    check("stop_ctrl", rdata, 32'd0);
    wr(8'h00, 32'h3);
    rd(8'h00, rdata);
    check("startstop_ctrl", rdata, 32'd0);
    check("startstop_pulse", 32'(pulse), 32'd0);

    // All channels active, then asynchronous reset
    wr(8'h00, 32'h1);
    wr(8'h24, 32'd6);
    wr(8'h28, 32'd6);
    wr(8'h20, 32'h1);
    wr(8'h34, 32'd2);
    wr(8'h38, 32'd1);
    wr(8'h3C, 32'd1);
    wr(8'h30, 32'h5);
    wr(8'h10, 32'h5);
    tick();
    tick();
    tick();
    check("pre_rst_irq", 32'(irq), 32'd1);
    check("pre_rst_ch2", 32'(pulse[2]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_pulse", 32'(pulse), 32'd0);
    check("async_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int a = 0; a < 64; a += 4) begin
      rd(8'(a), rdata);
      check($sformatf("rst_reg_%02h", a), rdata, 32'd0);
    end

    // Channel 7 does not exist
    wr(8'h74, 32'h55);
    rd(8'h74, rdata);
    check("ch7_period", rdata, 32'd0);
    wr(8'h70, 32'h1);
    rd(8'h70, rdata);
    check("ch7_ctrl", rdata, 32'd0);
    rd(8'h34, rdata);
    check("ch7_alias", rdata, 32'd0);
    check("ch7_pulse", 32'(pulse), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pulse_sched.md
Name: pulse_sched

Overview:
- Memory-mapped controller that owns NUM_CH independent pulse channels. Each channel has its own period/duty counter.
- Software programs period, duty and burst length per channel through the peripheral bus. It then starts and stops channels and gets an interrupt when a finite burst completes.
- Period/duty writes are double-buffered. Active values change only at a period boundary, so no runt or glitch pulses appear on the outputs.
- Sits on the peripheral bus next to the timer and drives board-level pulse/PWM pins.

Parameters:
- NUM_CH, 4, number of pulse channels (1..8).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- we_i  input  1  bus write strobe, one cycle per write
- addr_i  input  8  byte address; channel = addr_i[6:4], register = addr_i[3:2]
- data_i  input  32  write data
- data_o  output  32  read data, combinational from addr_i
- pulse_o  output  NUM_CH  per-channel pulse outputs
- irq_o  output  1  OR over channels of (done & irq_en)

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers, counters and states go to 0/IDLE.
  - pulse_o=0, irq_o=0, data_o follows the zeroed registers.
- Register map, per channel at offset ch*0x10:
  - 0x0 CTRL:
    - bit0 start: write-1 action, reads 0.
    - bit1 stop: write-1 action, reads 0.
    - bit2 irq_en: RW.
    - bit8 done: sticky, write-1-to-clear.
    - bit9 busy: RO, 1 when RUN.
  - 0x4 PERIOD: RW shadow, 32 bit.
  - 0x8 DUTY: RW shadow, 32 bit.
  - 0xC BURST: RW, number of periods; 0 = continuous.
- Address decode:
  - Channel index >= NUM_CH: reads 0, writes ignored.
  - Unused bits read 0.
- Writes:
  - take effect at the clk edge where we_i=1.
  - Reading CTRL returns the live busy/done.
- Per-channel registers: period_act, duty_act, cntr[31:0], per_cnt[31:0].
- FSM states:
  - IDLE:
    - pulse=0, cntr held at 0.
    - Start with shadow PERIOD!=0: go to RUN, load period_act/duty_act from shadows, cntr=0, per_cnt=0.
    - Start with PERIOD==0: ignored, stays IDLE.
  - RUN:
    - cntr increments each cycle.
    - At cntr==period_act-1: cntr->0 and per_cnt+1, and period_act/duty_act reload from shadows (boundary).
    - If BURST!=0 and per_cnt==BURST-1 at the boundary: go to IDLE, set done.
    - A shadow PERIOD of 0 seen at a boundary: go to IDLE without setting done.
- pulse_o[ch] = (state==RUN) && (cntr < duty_act). This is a registered-state compare with no extra latency, so the first high cycle is the cycle after the start edge.
- Duty edge cases:
  - duty_act==0: output stays low while the channel still counts.
  - duty_act>=period_act: output is constantly high.
- Start while RUN: restart. Reload shadows, cntr=0, per_cnt=0; done is unaffected.
- Stop: go to IDLE next edge and pulse drops immediately after that edge. done is not set.
- Start and stop in the same write: stop wins.
- Same-edge collisions:
  - Done set and W1C clear on the same edge: set wins.
  - Shadow write on the same edge as a boundary: the old shadow value is loaded, and the new value applies at the following boundary.
- BURST is sampled at each boundary. Lowering it below per_cnt+1 mid-run ends the burst at the next boundary.
- irq_o is level: it stays high until software clears done or irq_en.

Test Plan:
- Ch0 PERIOD=10, DUTY=3, BURST=0, start -> pulse_o[0] high 3 / low 7 cycles, repeating. busy=1, irq_o=0.
- Ch1 PERIOD=4, DUTY=2, BURST=3, irq_en=1, start -> exactly 3 pulses of 2 cycles. done=1, busy=0, irq_o=1 from cycle 12. W1C done -> irq_o=0 next cycle.
- Ch0 running PERIOD=8, DUTY=2. Write DUTY=6 at cntr=3 -> current period still ends high after 2 cycles, next period is high 6 cycles. No extra edges appear.
- DUTY=0 and DUTY=20 with PERIOD=10 -> constant low / constant high while busy=1. Start with PERIOD=0 -> stays IDLE, pulse 0.
- Stop mid-high (cntr=1, DUTY=5) -> pulse_o low the cycle after the write, busy=0, done=0. A start+stop single write -> channel stays IDLE.
- Assert rst low asynchronously mid-burst on all channels -> pulse_o=0 and irq_o=0 immediately, all registers read 0 after release. Access to channel 7 with NUM_CH=4 -> reads 0, writes have no effect.
